// File: rtl/scale_row_scheduler.sv
// Row scheduler for a vertical scaler: maps each requested destination row to
// a source row, fetches it through the line loader, and notifies the
// calculator once the row is resident. Tracks rows per frame and fetch timeouts.
module scale_row_scheduler #(
  parameter int unsigned SRC_ROWS  = 720,
  parameter int unsigned FLOAT_LEN = 11,
  parameter int unsigned TIMEOUT   = 4095
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        frame_start,
  input  logic [14:0] y_scale,
  input  logic [12:0] target_v_num,
  input  logic        row_req,
  input  logic [10:0] dst_row,
  output logic        rd_req,
  output logic [10:0] rd_row,
  input  logic        rd_ack,
  input  logic        rd_done,
  output logic        tran_done,
  output logic        frame_done,
  output logic        busy,
  output logic        err
);

  localparam int unsigned ROW_W  = 11;
  localparam int unsigned CNT_W  = 13;
  localparam int unsigned PROD_W = 26;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ARM       = 3'd1;
  localparam logic [2:0] S_CALC      = 3'd2;
  localparam logic [2:0] S_REQ       = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_NOTIFY    = 3'd5;
  localparam logic [2:0] S_FRAME_END = 3'd6;

  logic [2:0]        state_q, state_n;
  logic [CNT_W-1:0]  rows_q, rows_n;
  logic [TMO_W-1:0]  tcnt_q, tcnt_n;
  logic              rearm_q, rearm_n;
  logic [ROW_W-1:0]  dst_q, dst_n;
  logic              rd_req_n, tran_done_n, frame_done_n, busy_n, err_n;
  logic [ROW_W-1:0]  rd_row_n;

  logic [ROW_W-1:0]  dst_m1;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] src_idx;
  logic [ROW_W-1:0]  src_row;
  logic [CNT_W-1:0]  rows_inc;
  logic [CNT_W-1:0]  target;
  logic [TMO_W-1:0]  tcnt_inc;

  // Source-row mapping, saturating row count and timeout increment
  always_comb begin
    dst_m1   = (dst_q == '0) ? '0 : dst_q - ROW_W'(1);
    prod     = PROD_W'(dst_m1) * PROD_W'(y_scale);
    src_idx  = prod >> FLOAT_LEN;
    src_row  = (src_idx > PROD_W'(SRC_ROWS - 1)) ? ROW_W'(SRC_ROWS - 1) : ROW_W'(src_idx);
    rows_inc = (rows_q == '1) ? rows_q : rows_q + CNT_W'(1);
    target   = (target_v_num == '0) ? CNT_W'(1) : target_v_num;
    tcnt_inc = tcnt_q + TMO_W'(1);
  end

  // Next-state and next-output logic
  always_comb begin
    state_n  = state_q;
    rows_n   = rows_q;
    tcnt_n   = tcnt_q;
    rearm_n  = rearm_q;
    dst_n    = dst_q;
    rd_row_n = rd_row;
    err_n    = err;

    if (frame_start && (state_q != S_IDLE)) begin
      state_n = S_ARM;
      rows_n  = '0;
      tcnt_n  = '0;
      rearm_n = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            state_n = S_ARM;
            rows_n  = '0;
            tcnt_n  = '0;
            rearm_n = 1'b1;
          end
        end
        S_ARM: begin
          if (row_req && rearm_q) begin
            dst_n   = dst_row;
            rearm_n = 1'b0;
            state_n = S_CALC;
          end else if (!row_req) begin
            rearm_n = 1'b1;
          end
        end
        S_CALC: begin
          rd_row_n = src_row;
          state_n  = S_REQ;
        end
        S_REQ: begin
          if (rd_ack) state_n = rd_done ? S_NOTIFY : S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (rd_done) begin
            state_n = S_NOTIFY;
          end else begin
            tcnt_n = tcnt_inc;
            if (tcnt_inc == TMO_W'(TIMEOUT)) begin
              err_n   = 1'b1;
              state_n = S_IDLE;
            end
          end
        end
        S_NOTIFY: begin
          rows_n  = rows_inc;
          tcnt_n  = '0;
          state_n = (rows_inc == target) ? S_FRAME_END : S_ARM;
        end
        S_FRAME_END: state_n = S_IDLE;
        default:     state_n = S_IDLE;
      endcase
    end

    rd_req_n     = (state_n == S_REQ);
    tran_done_n  = (state_n == S_NOTIFY);
    frame_done_n = (state_n == S_FRAME_END);
    busy_n       = (state_n != S_IDLE);
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      rows_q     <= '0;
      tcnt_q     <= '0;
      rearm_q    <= 1'b0;
      dst_q      <= '0;
      rd_req     <= 1'b0;
      rd_row     <= '0;
      tran_done  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_n;
      rows_q     <= rows_n;
      tcnt_q     <= tcnt_n;
      rearm_q    <= rearm_n;
      dst_q      <= dst_n;
      rd_req     <= rd_req_n;
      rd_row     <= rd_row_n;
      tran_done  <= tran_done_n;
      frame_done <= frame_done_n;
      busy       <= busy_n;
      err        <= err_n;
    end
  end

endmodule

// File: tb/tb_scale_row_scheduler.sv
// Directed bench for scale_row_scheduler with hand-computed expectations.
module tb_scale_row_scheduler;

  localparam int TO = 4095;

  logic        clk;
  logic        rstn;
  logic        frame_start;
  logic [14:0] y_scale;
  logic [12:0] target_v_num;
  logic        row_req;
  logic [10:0] dst_row;
  logic        rd_req;
  logic [10:0] rd_row;
  logic        rd_ack;
  logic        rd_done;
  logic        tran_done;
  logic        frame_done;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  scale_row_scheduler dut (
    .clk(clk), .rstn(rstn), .frame_start(frame_start), .y_scale(y_scale),
    .target_v_num(target_v_num), .row_req(row_req), .dst_row(dst_row),
    .rd_req(rd_req), .rd_row(rd_row), .rd_ack(rd_ack), .rd_done(rd_done),
    .tran_done(tran_done), .frame_done(frame_done), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [12:0] tv);
    target_v_num = tv;
    frame_start  = 1'b1;
    tick();
    frame_start  = 1'b0;
  endtask

  // From ARM: drop row_req for one cycle, then request one row; ends in REQ
  task automatic issue_row(input logic [10:0] d);
    row_req = 1'b0;
    tick();
    row_req = 1'b1;
    dst_row = d;
    tick();
    row_req = 1'b0;
    tick();
  endtask

  task automatic ack_then_done();
    rd_ack = 1'b1;
    tick();
    rd_ack  = 1'b0;
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
  endtask

  task automatic ack_with_done();
    rd_ack  = 1'b1;
    rd_done = 1'b1;
    tick();
    rd_ack  = 1'b0;
    rd_done = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({rd_req, rd_row, tran_done, frame_done, busy, err} !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 0",
               {rd_req, rd_row, tran_done, frame_done, busy, err});
    end
  endtask

  task automatic test_unity();
    y_scale = 15'h0800;
    start_frame(13'd8);
    checks++;
    if (busy !== 1'b1 || rd_req !== 1'b0) begin
      errors++; $display("FAIL unity_arm busy=%b rd_req=%b expected 1 0", busy, rd_req);
    end
    issue_row(11'd5);
    checks++;
    if (rd_req !== 1'b1 || rd_row !== 11'd4) begin
      errors++; $display("FAIL unity_req rd_req=%b rd_row=%0d expected 1 4", rd_req, rd_row);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rd_req !== 1'b1) begin
        errors++; $display("FAIL unity_hold cycle %0d rd_req=%b expected 1", i, rd_req);
      end
    end
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    checks++;
    if (rd_req !== 1'b0 || tran_done !== 1'b0) begin
      errors++; $display("FAIL unity_wait rd_req=%b tran_done=%b expected 0 0", rd_req, tran_done);
    end
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    checks++;
    if (tran_done !== 1'b1) begin
      errors++; $display("FAIL unity_tran_done got %b expected 1", tran_done);
    end
    tick();
    checks++;
    if (tran_done !== 1'b0 || busy !== 1'b1 || frame_done !== 1'b0) begin
      errors++; $display("FAIL unity_pulse tran_done=%b busy=%b frame_done=%b expected 0 1 0",
                         tran_done, busy, frame_done);
    end
  endtask

  task automatic test_scale();
    y_scale = 15'h1000;
    issue_row(11'd360);
    checks++;
    if (rd_row !== 11'd718) begin
      errors++; $display("FAIL scale_2x got %0d expected 718", rd_row);
    end
    ack_with_done();
    checks++;
    if (tran_done !== 1'b1 || rd_req !== 1'b0) begin
      errors++; $display("FAIL scale_ack_done tran_done=%b rd_req=%b expected 1 0", tran_done, rd_req);
    end
    tick();
    y_scale = 15'h1800;
    issue_row(11'd300);
    checks++;
    if (rd_row !== 11'd719) begin
      errors++; $display("FAIL scale_clamp got %0d expected 719", rd_row);
    end
    ack_with_done();
    tick();
    issue_row(11'd0);
    checks++;
    if (rd_row !== 11'd0) begin
      errors++; $display("FAIL scale_dst0 got %0d expected 0", rd_row);
    end
    ack_with_done();
    tick();
    y_scale = 15'h0C00;
    issue_row(11'd4);
    checks++;
    if (rd_row !== 11'd4) begin
      errors++; $display("FAIL scale_frac got %0d expected 4", rd_row);
    end
    ack_with_done();
    tick();
  endtask

  task automatic test_back_to_back();
    y_scale = 15'h0800;
    start_frame(13'd3);
    for (int k = 1; k <= 3; k++) begin
      issue_row(11'(k));
      checks++;
      if (rd_row !== 11'(k - 1)) begin
        errors++; $display("FAIL frame_row%0d got %0d expected %0d", k, rd_row, k - 1);
      end
      ack_then_done();
      checks++;
      if (tran_done !== 1'b1 || frame_done !== 1'b0) begin
        errors++; $display("FAIL frame_notify%0d tran_done=%b frame_done=%b expected 1 0",
                           k, tran_done, frame_done);
      end
      tick();
      if (k < 3) begin
        checks++;
        if (frame_done !== 1'b0) begin
          errors++; $display("FAIL frame_early%0d frame_done=%b expected 0", k, frame_done);
        end
      end
    end
    checks++;
    if (frame_done !== 1'b1 || tran_done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL frame_end frame_done=%b tran_done=%b busy=%b expected 1 0 1",
                         frame_done, tran_done, busy);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL frame_idle frame_done=%b busy=%b expected 0 0", frame_done, busy);
    end
  endtask

  task automatic test_hold();
    y_scale = 15'h0800;
    start_frame(13'd2);
    issue_row(11'd10);
    for (int i = 0; i < 50; i++) begin
      checks++;
      if (rd_req !== 1'b1 || rd_row !== 11'd9) begin
        errors++; $display("FAIL hold cycle %0d rd_req=%b rd_row=%0d expected 1 9", i, rd_req, rd_row);
      end
      tick();
    end
    ack_with_done();
    checks++;
    if (tran_done !== 1'b1) begin
      errors++; $display("FAIL hold_notify tran_done=%b expected 1", tran_done);
    end
    tick();
  endtask

  task automatic test_target_zero();
    start_frame(13'd0);
    issue_row(11'd1);
    ack_then_done();
    tick();
    checks++;
    if (frame_done !== 1'b1) begin
      errors++; $display("FAIL target_zero frame_done=%b expected 1", frame_done);
    end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    int seen;
    start_frame(13'd2);
    issue_row(11'd3);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    n = 0;
    seen = 0;
    while (busy === 1'b1 && n < TO + 10) begin
      if (n == TO - 1) begin
        checks++;
        if (err !== 1'b0) begin
          errors++; $display("FAIL timeout_early err=%b expected 0", err);
        end
      end
      tick();
      n++;
      if (tran_done === 1'b1 || frame_done === 1'b1) seen++;
    end
    checks++;
    if (n != TO) begin
      errors++; $display("FAIL timeout_cycles got %0d expected %0d", n, TO);
    end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || rd_req !== 1'b0 || seen != 0) begin
      errors++; $display("FAIL timeout_state err=%b busy=%b rd_req=%b pulses=%0d expected 1 0 0 0",
                         err, busy, rd_req, seen);
    end
    start_frame(13'd2);
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_sticky got %b expected 1", err);
    end
    issue_row(11'd2);
    ack_then_done();
    tick();
    issue_row(11'd4);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++;
    if (rd_req !== 1'b0 || busy !== 1'b1 || err !== 1'b1) begin
      errors++; $display("FAIL abort rd_req=%b busy=%b err=%b expected 0 1 1", rd_req, busy, err);
    end
    issue_row(11'd5);
    ack_then_done();
    tick();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL abort_rows_cleared frame_done=%b expected 0", frame_done);
    end
    issue_row(11'd6);
    ack_then_done();
    tick();
    checks++;
    if (frame_done !== 1'b1) begin
      errors++; $display("FAIL abort_frame_end frame_done=%b expected 1", frame_done);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    start_frame(13'd2);
    issue_row(11'd2);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    rstn = 1'b0;
    tick();
    checks++;
    if ({rd_req, rd_row, tran_done, frame_done, busy, err} !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid got %h expected 0",
               {rd_req, rd_row, tran_done, frame_done, busy, err});
    end
    rstn = 1'b1;
    tick();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tran_done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL reset_late_done cycle %0d tran_done=%b busy=%b expected 0 0",
                           i, tran_done, busy);
      end
      tick();
    end
  endtask

  initial begin
    rstn = 1'b0;
    frame_start = 1'b0;
    y_scale = 15'h0800;
    target_v_num = 13'd1;
    row_req = 1'b0;
    dst_row = 11'd0;
    rd_ack = 1'b0;
    rd_done = 1'b0;
    tick();
    tick();
    test_reset();
    rstn = 1'b1;
    tick();
    test_unity();
    test_scale();
    test_back_to_back();
    test_hold();
    test_target_zero();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
